gelato_warp_scheduler: RTL
==========================

// Module: gelato_warp_scheduler
// PURPOSE
// - Per-SM warp scheduler: tracks every warp's lifecycle (IDLE/READY/WAIT) with its PC and thread mask.
// - Selects one READY warp per cycle and presents it to fetch/decode through a registered valid/ready issue slot.
// - Sits between the kernel launcher (launch), the front end (issue) and the branch/split-table unit (resume/exit).
// PARAMETERS
// - NUM_WARPS  default 8             number of hardware warp slots; must be a power of two, >= 2
// - WARP_W     default $clog2(NUM_WARPS)  index width; must match warp_num_t
// PORTS
// - clk           in   1            clock
// - rst           in   1            asynchronous, active-high reset
// - launch_valid  in   1            launcher requests warp start
// - launch_warp   in   WARP_W       slot to start
// - launch_pc     in   addr_t       start PC
// - launch_mask   in   thread_mask_t  initial active threads
// - launch_ready  out  1            target slot is IDLE (combinational from launch_warp)
// - issue_valid   out  1            issue slot holds a warp
// - issue_ready   in   1            front end accepts
// - issue_warp    out  WARP_W       issued warp id
// - issue_pc      out  addr_t       PC to fetch
// - issue_mask    out  thread_mask_t  active threads
// - resume_valid  in   1            warp's in-flight inst resolved; next PC/mask known
// - resume_warp   in   WARP_W       warp to resume
// - resume_pc     in   addr_t       next PC (after branch/reconvergence)
// - resume_mask   in   thread_mask_t  next active mask
// - exit_valid    in   1            warp executed exit
// - exit_warp     in   WARP_W       exiting warp
// - active_count  out  $clog2(NUM_WARPS+1)  number of non-IDLE warps
// - busy          out  1            active_count != 0 or issue_valid
// BEHAVIOUR
// - Reset (async, any time, incl. mid-handshake): all warps IDLE, pc/mask 0, rr_ptr 0, issue_valid 0,
//   issue_warp/pc/mask 0, active_count 0, busy 0. An in-flight handshake is dropped.
// - Warp FSM: IDLE -launch-> READY -selected into issue slot-> WAIT -resume-> READY; WAIT -exit-> IDLE.
// - Launch: handshake when launch_valid & launch_ready; state/pc/mask written at clock edge; READY next cycle.
// - Issue slot: loaded when empty or on the same edge as issue_valid & issue_ready (back-to-back issue, 1/cycle).
//   Loaded warp moves READY->WAIT at load, so it cannot be selected twice. Slot contents stable while
//   issue_valid & !issue_ready (no re-arbitration while held).
// - Latency: launch accepted at edge N -> READY after N -> issue_valid after edge N+1. Resume likewise 2 cycles.
// - Arbitration: round-robin; first READY warp at index >= rr_ptr, wrapping modulo NUM_WARPS; on load
//   rr_ptr <= selected+1 (wraps NUM_WARPS-1 -> 0). No READY warp: slot stays empty, rr_ptr unchanged.
// - Resume: only legal for a WAIT warp not held in the issue slot; updates pc/mask, -> READY.
//   resume_mask == 0 -> warp goes IDLE (implicit exit). Resume to non-WAIT warp is ignored (sim assertion).
// - Exit: WAIT -> IDLE. Exit and resume to same warp in same cycle: exit wins.
// - Simultaneous launch + resume/exit on different warps all take effect in the same cycle.
// - active_count registered, updated with state: +1 per launch, -1 per exit/zero-mask resume; never wraps.
// CONFIGURATION
// - GELATO_SCHED_GTO_EN defined: greedy-then-oldest; if last-issued warp is READY it is selected again
//   (rr_ptr unchanged), else fall back to oldest-launched READY warp via per-warp launch-age counters.
// - Not defined: pure round-robin as above; no age counters instantiated.
// STRUCTURE
// - gelato_types package gains: typedef enum logic [1:0] {WARP_IDLE, WARP_READY, WARP_WAIT} warp_state_e;
//   and a packed warp_entry_t {warp_state_e state; addr_t pc; thread_mask_t mask;}.
// - Uses existing addr_t, thread_mask_t, warp_num_t; NUM_WARPS default tracks the warp-count macro.
// - One sub-module: gelato_rr_arbiter (NUM_REQ, req vector, ptr -> grant_valid, grant_idx), pure comb.
// TESTING
// - Reset then launch warp 3 pc=0x100 mask=0xFFFF_FFFF, issue_ready=1 -> issue_valid 2 cycles later,
//   issue_warp=3, issue_pc=0x100; active_count=1.
// - Launch warps 0,1,2 together-ish, issue_ready=1, resume each after issue -> issue order 0,1,2,0,1,2.
// - Hold issue_ready=0 for 5 cycles while warp 5 becomes READY -> issue_warp/pc/mask unchanged throughout.
// - Launch to a READY warp -> launch_ready=0, no state change; exit+resume same warp same cycle -> IDLE.
// - Resume warp 2 with mask=0 -> warp 2 IDLE, active_count decrements, never re-issued.
// - Assert rst with issue_valid=1 and 4 warps active -> next cycle issue_valid=0, active_count=0, busy=0.

Source files
------------

// File: rtl/gelato_warp_scheduler_pkg.sv
// Shared types for the warp scheduler: address/mask/warp-id types plus per-warp bookkeeping entry.
package gelato_warp_scheduler_pkg;

  localparam int GELATO_NUM_WARPS = 8;
  localparam int ADDR_W           = 32;
  localparam int THREADS_PER_WARP = 32;

  typedef logic [ADDR_W-1:0]                   addr_t;
  typedef logic [THREADS_PER_WARP-1:0]         thread_mask_t;
  typedef logic [$clog2(GELATO_NUM_WARPS)-1:0] warp_num_t;

  typedef enum logic [1:0] {
    WARP_IDLE,
    WARP_READY,
    WARP_WAIT
  } warp_state_e;

  typedef struct packed {
    warp_state_e  state;
    addr_t        pc;
    thread_mask_t mask;
  } warp_entry_t;

endpackage

// File: rtl/gelato_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping around.
module gelato_rr_arbiter #(
  parameter  int NUM_REQ = 8,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               grant_valid,
  output logic [IDX_W-1:0]   grant_idx
);

  logic [IDX_W-1:0] idx;

  // NOTE: every signal written here gets a default before any conditional
  // assignment, otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = ptr;
    idx         = ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ptr + IDX_W'(k);
      if (!grant_valid && req[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = idx;
      end
    end
  end

endmodule

// File: rtl/gelato_warp_scheduler.sv
// Per-SM warp scheduler with a registered valid/ready issue slot.
// Define GELATO_SCHED_GTO_EN for greedy-then-oldest selection instead of round-robin.
module gelato_warp_scheduler
  import gelato_warp_scheduler_pkg::*;
#(
  parameter  int NUM_WARPS = GELATO_NUM_WARPS,
  parameter  int WARP_W    = $clog2(NUM_WARPS),
  localparam int CNT_W     = $clog2(NUM_WARPS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              launch_valid,
  input  logic [WARP_W-1:0] launch_warp,
  input  addr_t             launch_pc,
  input  thread_mask_t      launch_mask,
  output logic              launch_ready,
  output logic              issue_valid,
  input  logic              issue_ready,
  output logic [WARP_W-1:0] issue_warp,
  output addr_t             issue_pc,
  output thread_mask_t      issue_mask,
  input  logic              resume_valid,
  input  logic [WARP_W-1:0] resume_warp,
  input  addr_t             resume_pc,
  input  thread_mask_t      resume_mask,
  input  logic              exit_valid,
  input  logic [WARP_W-1:0] exit_warp,
  output logic [CNT_W-1:0]  active_count,
  output logic              busy
);

  warp_entry_t       warps_q [NUM_WARPS];
  warp_entry_t       warps_d [NUM_WARPS];
  logic              issue_valid_q, issue_valid_d;
  logic [WARP_W-1:0] issue_warp_q, issue_warp_d;
  addr_t             issue_pc_q, issue_pc_d;
  thread_mask_t      issue_mask_q, issue_mask_d;
  logic [WARP_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]  active_count_q, active_count_d;

  logic [NUM_WARPS-1:0] ready_vec;
  logic [NUM_WARPS-1:0] arb_req;
  logic                 grant_valid;
  logic [WARP_W-1:0]    grant_idx;
  logic                 sel_valid;
  logic [WARP_W-1:0]    sel_idx;
  logic                 rr_advance;
  logic                 slot_free, do_load, launch_fire;
  logic                 resume_ok, exit_ok;

  assign launch_ready = (warps_q[launch_warp].state == WARP_IDLE);
  assign launch_fire  = launch_valid && launch_ready;
  assign slot_free    = !issue_valid_q || issue_ready;
  assign do_load      = slot_free && sel_valid;

  // The warp sitting in the issue slot has not reached the front end yet, so it cannot resolve.
  assign resume_ok = resume_valid && (warps_q[resume_warp].state == WARP_WAIT) &&
                     !(issue_valid_q && (issue_warp_q == resume_warp));
  assign exit_ok   = exit_valid && (warps_q[exit_warp].state == WARP_WAIT);

  always_comb begin
    ready_vec = '0;
    for (int i = 0; i < NUM_WARPS; i++) begin
      ready_vec[i] = (warps_q[i].state == WARP_READY);
    end
  end

  gelato_rr_arbiter #(.NUM_REQ(NUM_WARPS)) u_arb (
    .req         (arb_req),
    .ptr         (rr_ptr_q),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

`ifdef GELATO_SCHED_GTO_EN
  localparam int AGE_W = 8;

  logic [AGE_W-1:0]  age_q [NUM_WARPS];
  logic [AGE_W-1:0]  age_d [NUM_WARPS];
  logic [AGE_W-1:0]  max_age;
  logic [WARP_W-1:0] last_q, last_d;
  logic              last_valid_q, last_valid_d;
  logic              greedy;

  // Age counts launches seen since a warp's own launch; the largest age is the oldest warp.
  always_comb begin
    max_age = '0;
    arb_req = '0;
    for (int i = 0; i < NUM_WARPS; i++) begin
      if (ready_vec[i] && (age_q[i] > max_age)) max_age = age_q[i];
    end
    for (int i = 0; i < NUM_WARPS; i++) begin
      arb_req[i] = ready_vec[i] && (age_q[i] == max_age);
    end
    greedy     = last_valid_q && ready_vec[last_q];
    sel_valid  = greedy || grant_valid;
    sel_idx    = greedy ? last_q : grant_idx;
    rr_advance = !greedy;
    age_d      = age_q;
    if (launch_fire) begin
      for (int i = 0; i < NUM_WARPS; i++) begin
        if (WARP_W'(i) == launch_warp) age_d[i] = '0;
        else if (age_q[i] != '1)       age_d[i] = age_q[i] + AGE_W'(1);
      end
    end
  end

  always_comb begin
    last_d       = last_q;
    last_valid_d = last_valid_q;
    if (do_load) begin
      last_d       = sel_idx;
      last_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_WARPS; i++) age_q[i] <= '0;
      last_q       <= '0;
      last_valid_q <= 1'b0;
    end else begin
      age_q        <= age_d;
      last_q       <= last_d;
      last_valid_q <= last_valid_d;
    end
  end
`else
  always_comb begin
    arb_req    = ready_vec;
    sel_valid  = grant_valid;
    sel_idx    = grant_idx;
    rr_advance = 1'b1;
  end
`endif

  // Later assignments override earlier ones, so exit beats resume on the same warp.
  always_comb begin
    warps_d = warps_q;
    if (launch_fire) begin
      warps_d[launch_warp] = '{state: WARP_READY, pc: launch_pc, mask: launch_mask};
    end
    if (do_load) begin
      warps_d[sel_idx].state = WARP_WAIT;
    end
    if (resume_ok) begin
      warps_d[resume_warp].pc    = resume_pc;
      warps_d[resume_warp].mask  = resume_mask;
      warps_d[resume_warp].state = (resume_mask == '0) ? WARP_IDLE : WARP_READY;
    end
    if (exit_ok) begin
      warps_d[exit_warp].state = WARP_IDLE;
    end
  end

  always_comb begin
    active_count_d = '0;
    for (int i = 0; i < NUM_WARPS; i++) begin
      if (warps_d[i].state != WARP_IDLE) active_count_d = active_count_d + CNT_W'(1);
    end
  end

  always_comb begin
    issue_valid_d = issue_valid_q;
    issue_warp_d  = issue_warp_q;
    issue_pc_d    = issue_pc_q;
    issue_mask_d  = issue_mask_q;
    rr_ptr_d      = rr_ptr_q;
    if (do_load) begin
      issue_valid_d = 1'b1;
      issue_warp_d  = sel_idx;
      issue_pc_d    = warps_q[sel_idx].pc;
      issue_mask_d  = warps_q[sel_idx].mask;
      if (rr_advance) rr_ptr_d = sel_idx + WARP_W'(1);
    end else if (slot_free) begin
      issue_valid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the warp table is reset entry by entry; software relies on IDLE/pc=0/mask=0
      // after reset, so it must not be left as uninitialised storage.
      for (int i = 0; i < NUM_WARPS; i++) begin
        warps_q[i] <= '{state: WARP_IDLE, pc: '0, mask: '0};
      end
      issue_valid_q  <= 1'b0;
      issue_warp_q   <= '0;
      issue_pc_q     <= '0;
      issue_mask_q   <= '0;
      rr_ptr_q       <= '0;
      active_count_q <= '0;
    end else begin
      warps_q        <= warps_d;
      issue_valid_q  <= issue_valid_d;
      issue_warp_q   <= issue_warp_d;
      issue_pc_q     <= issue_pc_d;
      issue_mask_q   <= issue_mask_d;
      rr_ptr_q       <= rr_ptr_d;
      active_count_q <= active_count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && resume_valid) begin
      assert (warps_q[resume_warp].state == WARP_WAIT)
        else $error("resume to non-WAIT warp %0d", resume_warp);
    end
  end

  assign issue_valid  = issue_valid_q;
  assign issue_warp   = issue_warp_q;
  assign issue_pc     = issue_pc_q;
  assign issue_mask   = issue_mask_q;
  assign active_count = active_count_q;
  assign busy         = (active_count_q != '0) || issue_valid_q;

endmodule
